// File: rtl/sub4b_serial.sv
// Bit-serial 4-bit subtractor A-B, LSB first, one full-subtractor cell and a registered borrow.
// Result latency: done pulses in the cycle after the 4th processing edge; start is ignored while busy.
module sub4b_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] Diff,
  output logic       Bout,
  output logic       Ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] idx_q, idx_d;
  logic       brw_q, brw_d;
  logic [2:0] acc_q, acc_d;
  logic [3:0] diff_q, diff_d;
  logic       bout_q, bout_d;
  logic       ovf_q, ovf_d;

  logic abit, bbit, dbit, bnext;

  // The single full-subtractor cell, fed from the bit selected by idx_q.
  assign abit  = a_q[idx_q];
  assign bbit  = b_q[idx_q];
  assign dbit  = abit ^ bbit ^ brw_q;
  assign bnext = (~abit & bbit) | (~(abit ^ bbit) & brw_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          idx_d   = 2'd0;
          brw_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Partial difference bits shift in from the top; after bit 2 acc holds {d2,d1,d0}.
        acc_d = {dbit, acc_q[2:1]};
        brw_d = bnext;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          diff_d  = {dbit, acc_q};
          bout_d  = bnext;
          ovf_d   = (a_q[3] ^ b_q[3]) & (dbit ^ a_q[3]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      idx_q   <= 2'd0;
      brw_q   <= 1'b0;
      acc_q   <= 3'd0;
      diff_q  <= 4'd0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_sub4b_serial.sv
// Randomized and directed bench for sub4b_serial against an integer-arithmetic reference model.
module tb_sub4b_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Diff;
  logic       Bout;
  logic       Ovf;

  int total = 0;
  int bad   = 0;

  sub4b_serial dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout),
    .Ovf  (Ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer subtraction, signed range check for overflow.
  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] d, output logic bo, output logic ov);
    int ru, sa, sb, rs;
    ru = int'(a) - int'(b);
    d  = ru[3:0];
    bo = (ru < 0);
    sa = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    sb = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
    rs = sa - sb;
    ov = (rs < -8) || (rs > 7);
  endfunction

  // Pulses start for one cycle, scrambles A/B afterwards, and waits (bounded) for done.
  // lat = negedges after the accepting edge at which done is first seen, 0 if never.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = 4'($urandom_range(0, 15));
    B     = 4'($urandom_range(0, 15));
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    start = 1'b1;
    A     = 4'd9;
    B     = 4'd3;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, Diff, Bout, Ovf} !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b Diff=%h Bout=%b Ovf=%b, want all 0",
               busy, done, Diff, Bout, Ovf);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_after_release: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors;
    logic [3:0] ta [8] = '{4'd9, 4'd3, 4'd8, 4'd0, 4'd5, 4'd15, 4'd7, 4'd0};
    logic [3:0] tb [8] = '{4'd3, 4'd9, 4'd1, 4'd0, 4'd5, 4'd1,  4'd8, 4'd15};
    logic [3:0] a, b, ed;
    logic       eb, eo;
    int         lat;
    bit         bok;
    for (int n = 0; n < 40; n++) begin
      if (n < 8) begin
        a = ta[n];
        b = tb[n];
      end else begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
      model(a, b, ed, eb, eo);
      do_op(a, b, lat, bok);
      total++;
      if (lat != 5) begin
        bad++;
        $display("FAIL latency a=%0d b=%0d: got %0d cycles, want 5", a, b, lat);
      end
      total++;
      if (!bok) begin
        bad++;
        $display("FAIL busy_during_run a=%0d b=%0d: busy not high through RUN / low in DONE", a, b);
      end
      total++;
      if (Diff !== ed || Bout !== eb || Ovf !== eo) begin
        bad++;
        $display("FAIL result a=%0d b=%0d: got Diff=%0d Bout=%b Ovf=%b, want Diff=%0d Bout=%b Ovf=%b",
                 a, b, Diff, Bout, Ovf, ed, eb, eo);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || Diff !== ed || Bout !== eb || Ovf !== eo) begin
        bad++;
        $display("FAIL hold_after_done a=%0d b=%0d: got done=%b busy=%b Diff=%0d, want 0 0 %0d",
                 a, b, done, busy, Diff, ed);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone, first;
    ndone = 0;
    first = 0;
    @(negedge clk);
    start = 1'b1;
    A     = 4'd7;
    B     = 4'd2;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) begin
        A = 4'd1;
        B = 4'd4;
      end
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = i;
          total++;
          if (Diff !== 4'd5 || Bout !== 1'b0 || Ovf !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored_result: got Diff=%0d Bout=%b Ovf=%b, want 5 0 0",
                     Diff, Bout, Ovf);
          end
        end
      end
    end
    total++;
    if (ndone != 1 || first != 5) begin
      bad++;
      $display("FAIL start_ignored_done: got %0d done pulses first at %0d, want 1 at 5", ndone, first);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b, ed;
    logic       eb, eo, edn;
    int         errs;
    errs = 0;
    a = 4'd6;
    b = 4'd1;
    model(a, b, ed, eb, eo);
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      edn = (i % 5 == 0);
      total++;
      if (done !== edn || busy !== !edn) begin
        bad++;
        errs++;
        $display("FAIL b2b_timing cycle %0d: got done=%b busy=%b, want done=%b busy=%b",
                 i, done, busy, edn, !edn);
      end
      if (edn && done) begin
        total++;
        if (Diff !== ed || Bout !== eb || Ovf !== eo) begin
          bad++;
          $display("FAIL b2b_result cycle %0d: got Diff=%0d Bout=%b Ovf=%b, want %0d %b %b",
                   i, Diff, Bout, Ovf, ed, eb, eo);
        end
        if (i >= 10) begin
          a = 4'($urandom_range(0, 15));
          b = 4'($urandom_range(0, 15));
        end
        model(a, b, ed, eb, eo);
        A = a;
        B = b;
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort;
    int nd, lat;
    bit bok;
    nd = 0;
    @(negedge clk);
    start = 1'b1;
    A     = 4'd2;
    B     = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, Diff, Bout, Ovf} !== 8'd0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b Diff=%0d Bout=%b Ovf=%b, want all 0",
               busy, done, Diff, Bout, Ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    total++;
    if (nd != 0 || Diff !== 4'd0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d active cycles Diff=%0d, want 0 and 0", nd, Diff);
    end
    do_op(4'd4, 4'd1, lat, bok);
    total++;
    if (lat != 5 || Diff !== 4'd3 || Bout !== 1'b0 || Ovf !== 1'b0) begin
      bad++;
      $display("FAIL abort_recover: got lat=%0d Diff=%0d Bout=%b Ovf=%b, want 5 3 0 0",
               lat, Diff, Bout, Ovf);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = 4'd0;
    B     = 4'd0;
    test_reset;
    test_vectors;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub4b_serial.md
SUB4B_SERIAL -- requirements
Module: sub4b_serial

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction A-B; sampled on rising clk.
REQ-005 A  input  4  minuend, unsigned or two's complement; sampled only when start is accepted.
REQ-006 B  input  4  subtrahend, same encoding as A; sampled only when start is accepted.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse marking the final Diff/Bout/Ovf results.
REQ-009 Diff  output  4  result A-B modulo 16.
REQ-010 Bout  output  1  unsigned borrow out; 1 iff A<B unsigned.
REQ-011 Ovf  output  1  signed overflow of A-B in 4-bit two's complement.

Function
REQ-012 The block SHALL compute A-B bit-serially, LSB first, one bit per clk cycle, using a single 1-bit full-subtractor cell and a registered borrow.
REQ-013 Per-bit rule: d = a XOR b XOR bin; bout = (NOT a AND b) OR (NOT(a XOR b) AND bin); bin for bit 0 is 0.
REQ-014 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at an edge latches A, B, clears borrow, sets bit index 0, goes to RUN; start=0 stays in IDLE.
REQ-016 RUN: each edge processes bit[index] and increments index; the edge processing bit 3 goes to DONE.
REQ-017 DONE: lasts exactly one cycle; done=1; the next edge goes to IDLE, or to RUN if start=1 (back-to-back accept, new A/B latched).
REQ-018 Latency: start accepted at edge k; bits processed at edges k+1..k+4; done=1 during the cycle after edge k+4.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 start while in RUN SHALL be ignored; latched operands are unaffected by A/B changes after acceptance.
REQ-021 Partial bits SHALL accumulate in an internal register; Diff, Bout and Ovf SHALL update only at the edge entering DONE and hold until the next completion.
REQ-022 Bout = final borrow out of bit 3.
REQ-023 Ovf = (A[3] XOR B[3]) AND (Diff[3] XOR A[3]), using the latched operands.
REQ-024 Wrap-around: results are modulo 16 with no saturation.

Reset
REQ-025 While rst=1: state IDLE, busy=0, done=0, Diff=4'b0000, Bout=0, Ovf=0, index=0, borrow=0, latched operands cleared.
REQ-026 rst asserted mid-RUN SHALL abort immediately; no done pulse is produced and outputs hold reset values.
REQ-027 start is ignored while rst=1; the first edge with rst=0 and start=1 is accepted normally.

Verification
REQ-028 A=9, B=3, start 1 cycle -> done 5 cycles after the start edge; Diff=6, Bout=0, Ovf=1 (-7-3 overflows).
REQ-029 A=3, B=9 -> Diff=4'b1010, Bout=1, Ovf=1; A=8, B=1 -> Diff=7, Bout=0, Ovf=1.
REQ-030 A=0, B=0 -> Diff=0, Bout=0, Ovf=0; A=5, B=5 -> Diff=0, Bout=0, Ovf=0.
REQ-031 Start A=7, B=2, then start pulse with A=1, B=4 two cycles later -> second start ignored; single done with Diff=5, Bout=0.
REQ-032 start held high continuously with A=6, B=1 -> done every 5 cycles, each time Diff=5; busy low only during DONE.
REQ-033 rst pulsed during the 3rd RUN cycle of A=2, B=7 -> no done; all outputs 0; a new start with A=4, B=1 yields Diff=3 after 5 cycles.
